// File: rtl/modexp_engine.sv
// modexp_engine: result = base^exponent mod modulus by right-to-left square-and-multiply over shift-add mulmod (in: clk rst start base exponent modulus; out: busy done result)
module modexp_engine #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exponent,
  input  logic [W-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, DONE} state_t;
  state_t state;
  logic [W-1:0] base_q, exp_q, n_q, b, r, mop;
  logic [W:0] acc, nn, aop, d, d1, e, e1;
  logic [CW-1:0] j, i;
  always_comb begin
    nn = {1'b0, n_q};
    mop = state == REDUCE ? base_q : b;
    aop = state == REDUCE ? (W+1)'(1) : state == MUL ? {1'b0, r} : {1'b0, b};
    d = acc + acc;
    d1 = d >= nn ? d - nn : d;
    e = d1 + (mop[j] ? aop : '0);
    e1 = e >= nn ? e - nn : e;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      base_q <= '0;
      exp_q  <= '0;
      n_q    <= '0;
      b      <= '0;
      r      <= '0;
      acc    <= '0;
      j      <= '0;
      i      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            n_q    <= modulus;
            r      <= modulus > W'(1) ? W'(1) : '0;
            acc    <= '0;
            j      <= CW'(W-1);
            i      <= '0;
            busy   <= 1'b1;
            state  <= REDUCE;
          end
        end
        REDUCE: begin
          acc <= j == '0 ? '0 : e1;
          j   <= j - 1'b1;
          if (j == '0) begin
            b     <= e1[W-1:0];
            state <= MUL;
          end
        end
        MUL: begin
          acc <= j == '0 ? '0 : e1;
          j   <= j - 1'b1;
          if (j == '0) begin
            if (exp_q[i]) r <= e1[W-1:0];
            state <= SQR;
          end
        end
        SQR: begin
          acc <= j == '0 ? '0 : e1;
          j   <= j - 1'b1;
          if (j == '0) begin
            b     <= e1[W-1:0];
            i     <= i + 1'b1;
            state <= MUL;
          end
          // the last square is discarded, so its final step is replaced by DONE
          if (i == CW'(W-1) && j == CW'(1)) state <= DONE;
        end
        DONE: begin
          result <= n_q == '0 ? '0 : r;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
